// File: rtl/hilo_muldiv_ctrl_if.sv
// EXE-stage mul/div request, WB MTHI/MTLO write and HI/LO read bundle.
// master drives the pipeline side, slave is the HI/LO controller.
interface hilo_muldiv_ctrl_if;
    logic        EXE_MDValid;
    logic [3:0]  EXE_MDOp;
    logic [31:0] EXE_SrcA;
    logic [31:0] EXE_SrcB;
    logic        EXE_Flush;
    logic        WB_HIWr;
    logic        WB_LOWr;
    logic [31:0] WB_HILOData;
    logic        MD_Stall;
    logic        MD_Busy;
    logic [31:0] HI_Data;
    logic [31:0] LO_Data;

    modport master (
        output EXE_MDValid, EXE_MDOp, EXE_SrcA, EXE_SrcB, EXE_Flush,
        output WB_HIWr, WB_LOWr, WB_HILOData,
        input  MD_Stall, MD_Busy, HI_Data, LO_Data
    );

    modport slave (
        input  EXE_MDValid, EXE_MDOp, EXE_SrcA, EXE_SrcB, EXE_Flush,
        input  WB_HIWr, WB_LOWr, WB_HILOData,
        output MD_Stall, MD_Busy, HI_Data, LO_Data
    );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle HI/LO multiply/divide controller for the EXE stage.
// Define HILO_MADD_EN to add MADD/MADDU/MSUB/MSUBU via an accumulate (ACC) state.
module hilo_muldiv_ctrl #(
    parameter int unsigned MUL_CYCLES  = 3,
    parameter bit          DIV_ZERO_WR = 1'b0
) (
    input logic               clk,
    input logic               rst,
    hilo_muldiv_ctrl_if.slave md
);

`ifdef HILO_MADD_EN
    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone, StAcc} state_e;
`else
    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;
`endif

    state_e      state;
    logic [4:0]  cnt;
    logic [31:0] hi_q, lo_q;
    logic [31:0] res_hi, res_lo;
    logic [31:0] dvsr;
    logic        neg_quo, neg_rem;
    logic        wr_en;

    logic        op_mul, op_div, op_sgn;
    logic        accept, commit, busy_st;
    logic [31:0] src_a, src_b, a_mag, b_mag;
    logic [63:0] a_ext, b_ext, prod;
    logic [32:0] rem_sh, diff;

`ifdef HILO_MADD_EN
    logic        op_acc, op_sub;
    logic        acc_en, acc_sub;
    logic [63:0] acc_sum;
`endif

    assign src_a = md.EXE_SrcA;
    assign src_b = md.EXE_SrcB;

    always_comb begin
        op_mul = 1'b0;
        op_div = 1'b0;
        op_sgn = 1'b0;
`ifdef HILO_MADD_EN
        op_acc = 1'b0;
        op_sub = 1'b0;
`endif
        case (md.EXE_MDOp)
            4'd1: begin op_mul = 1'b1; op_sgn = 1'b1; end
            4'd2: op_mul = 1'b1;
            4'd3: begin op_div = 1'b1; op_sgn = 1'b1; end
            4'd4: op_div = 1'b1;
`ifdef HILO_MADD_EN
            4'd5: begin op_mul = 1'b1; op_sgn = 1'b1; op_acc = 1'b1; end
            4'd6: begin op_mul = 1'b1; op_acc = 1'b1; end
            4'd7: begin op_mul = 1'b1; op_sgn = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
            4'd8: begin op_mul = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    // Gating with rst keeps the stall low while reset is asserted, even with a request pending.
    assign accept = rst && (state == StIdle) && md.EXE_MDValid && (op_mul || op_div) &&
                    !md.EXE_Flush;

    always_comb begin
        busy_st = (state == StMul) || (state == StDiv) || (state == StFix);
`ifdef HILO_MADD_EN
        if (state == StAcc) busy_st = 1'b1;
`endif
    end

    assign commit      = (state == StDone) && wr_en && !md.EXE_Flush;
    assign md.MD_Stall = accept || (busy_st && !md.EXE_Flush);
    assign md.MD_Busy  = (state != StIdle);
    assign md.HI_Data  = commit ? res_hi : (md.WB_HIWr ? md.WB_HILOData : hi_q);
    assign md.LO_Data  = commit ? res_lo : (md.WB_LOWr ? md.WB_HILOData : lo_q);

    assign a_ext = op_sgn ? {{32{src_a[31]}}, src_a} : {32'd0, src_a};
    assign b_ext = op_sgn ? {{32{src_b[31]}}, src_b} : {32'd0, src_b};
    assign prod  = a_ext * b_ext;
    assign a_mag = (op_sgn && src_a[31]) ? (32'd0 - src_a) : src_a;
    assign b_mag = (op_sgn && src_b[31]) ? (32'd0 - src_b) : src_b;

    // During DIV res_hi is the partial remainder and res_lo shifts dividend out, quotient in.
    assign rem_sh = {res_hi, res_lo[31]};
    assign diff   = rem_sh - {1'b0, dvsr};

`ifdef HILO_MADD_EN
    assign acc_sum = acc_sub ? ({md.HI_Data, md.LO_Data} - {res_hi, res_lo})
                             : ({md.HI_Data, md.LO_Data} + {res_hi, res_lo});
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= StIdle;
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_hi  <= '0;
            res_lo  <= '0;
            dvsr    <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            wr_en   <= 1'b0;
`ifdef HILO_MADD_EN
            acc_en  <= 1'b0;
            acc_sub <= 1'b0;
`endif
        end else begin
            // The DONE commit belongs to the younger instruction, so it beats MTHI/MTLO.
            if (commit) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else begin
                if (md.WB_HIWr) hi_q <= md.WB_HILOData;
                if (md.WB_LOWr) lo_q <= md.WB_HILOData;
            end

            unique case (state)
                StIdle: begin
                    if (accept) begin
                        wr_en <= 1'b1;
`ifdef HILO_MADD_EN
                        acc_en  <= op_acc;
                        acc_sub <= op_sub;
`endif
                        if (op_mul) begin
                            {res_hi, res_lo} <= prod;
                            cnt              <= 5'(MUL_CYCLES - 1);
                            state            <= StMul;
                        end else if (src_b == '0) begin
                            wr_en  <= DIV_ZERO_WR;
                            res_hi <= src_a;
                            res_lo <= '1;
                            state  <= StDone;
                        end else begin
                            res_hi  <= '0;
                            res_lo  <= a_mag;
                            dvsr    <= b_mag;
                            cnt     <= 5'd31;
                            neg_quo <= op_sgn && (src_a[31] ^ src_b[31]);
                            neg_rem <= op_sgn && src_a[31];
                            state   <= StDiv;
                        end
                    end
                end
                StMul: begin
                    if (md.EXE_Flush) begin
                        state <= StIdle;
                    end else if (cnt == '0) begin
`ifdef HILO_MADD_EN
                        state <= acc_en ? StAcc : StDone;
`else
                        state <= StDone;
`endif
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                StDiv: begin
                    if (md.EXE_Flush) begin
                        state <= StIdle;
                    end else begin
                        if (!diff[32]) begin
                            res_hi <= diff[31:0];
                            res_lo <= {res_lo[30:0], 1'b1};
                        end else begin
                            res_hi <= rem_sh[31:0];
                            res_lo <= {res_lo[30:0], 1'b0};
                        end
                        if (cnt == '0) state <= StFix;
                        else cnt <= cnt - 5'd1;
                    end
                end
                StFix: begin
                    if (md.EXE_Flush) begin
                        state <= StIdle;
                    end else begin
                        if (neg_quo) res_lo <= 32'd0 - res_lo;
                        if (neg_rem) res_hi <= 32'd0 - res_hi;
                        state <= StDone;
                    end
                end
`ifdef HILO_MADD_EN
                StAcc: begin
                    if (md.EXE_Flush) begin
                        state <= StIdle;
                    end else begin
                        {res_hi, res_lo} <= acc_sum;
                        state            <= StDone;
                    end
                end
`endif
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule
